dual_core_mem_arbiter: RTL and testbench
========================================

# dual_core_mem_arbiter

Shares one single-port data memory between the two cores of the dual-core MIPS (core A and core B), each of which issues loads and stores from its M stage. Each core gets a stall signal while its access is pending. Each core gets a registered read-data return when its access completes. Simultaneous requests are resolved round-robin. The block sits between the cores' `*_aluoutM`/`*_writedataM`/`*_memwriteM` outputs and the shared memory, which handshakes with variable latency.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `clk` in 1: system clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `a_req` in 1: core A M-stage memory access valid
- `a_we` in 1: core A access is a store
- `a_addr` in AW: core A byte address
- `a_wdata` in DW: core A store data
- `a_rdata` out DW: core A load data, registered
- `a_stall` out 1: hold core A pipeline
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_rdata`, `b_stall`: same as core A, for core B
- `mem_req` out 1: access valid to memory, registered
- `mem_we` out 1: store strobe
- `mem_addr` out AW: memory address
- `mem_wdata` out DW: memory store data
- `mem_ready` in 1: memory completes the access this cycle; `mem_rdata` is valid
- `mem_rdata` in DW: memory load data
- `last_grant` out 1: owner of the last completed access (0 = A, 1 = B)

## Operation
- FSM states: IDLE, GNT_A, GNT_B.
- Effective request: `x_eff = x_req & ~x_done`.
  - `x_done` is an internal one-cycle completion flag.
  - While `x_done` = 1 the core is still presenting its just-finished access, so it must not be re-granted.
- IDLE:
  - Only `a_eff` → GNT_A. Only `b_eff` → GNT_B.
  - Both → grant the core ≠ `last_grant`. Neither → stay in IDLE.
  - On a grant, latch the winner's we/addr/wdata into the `mem_*` registers and set `mem_req` = 1.
- GNT_x:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable until `mem_ready` is sampled high.
  - On `mem_ready`:
    - `mem_req` ← 0.
    - If the access is a load, `x_rdata` ← `mem_rdata`; stores leave `x_rdata` unchanged.
    - `x_done` ← 1 for exactly one cycle.
    - `last_grant` ← x.
    - Next state is IDLE.
  - `mem_ready` is ignored in IDLE.
- Stall, combinational: `x_stall = x_req & ~x_done`.
  - The stall is asserted in the same cycle the request appears.
  - The stall is released in the `x_done` cycle, and the core advances at the end of that cycle.
- Request withdrawn while granted (e.g. `x_req` drops on a flush): the memory transaction still completes and `x_done` still pulses. No effect on the stall. `x_rdata` is updated normally.
- Requests from the other core during GNT_x wait; that core's stall stays high.
- Address and data pass through unmodified. There is no width conversion and no alignment checking.

## Timing
- Reset values:
  - state IDLE
  - `mem_req`, `mem_we` = 0
  - `mem_addr`, `mem_wdata`, `a_rdata`, `b_rdata` = 0
  - `a_done`, `b_done` = 0
  - `last_grant` = 1, so A wins the first tie
  - `a_stall`/`b_stall` follow their request inputs
- Reset mid-transaction: asynchronous abort. `mem_req` drops immediately and the pending access is lost.
- Minimum single-access latency, request seen at cycle 0 in IDLE:
  - `mem_req` high in cycle 1.
  - `mem_ready` earliest in cycle 1.
  - `x_done`/stall release in cycle 2. The stall is therefore high for 2 cycles (0–1).
- Each extra memory wait cycle adds one stall cycle.
- Back-to-back sharing: in A's `done` cycle the FSM is in IDLE, so a pending B request is granted in that same cycle and `mem_req` for B is high the next cycle. There are no bubble cycles on the memory side beyond the IDLE cycle.
- Starvation bound: a waiting core is served after at most one access by the other core.

## Test plan
- Reset → all outputs at reset values. Single A load, addr 0x40, memory returns 0xDEADBEEF with `mem_ready` in cycle 1 → `a_stall` high cycles 0–1, `a_rdata` = 0xDEADBEEF in cycle 2, `last_grant` = 0.
- A and B both request in cycle 0 after reset → A granted first. B's `mem_req` rises in A's done cycle + 1. B is done two cycles after A's done cycle. Next simultaneous tie goes to A again only after B has been served.
- Memory with 3 wait cycles on a B store, addr 0x80, data 0x12345678 → `mem_addr`/`mem_wdata`/`mem_we` stable for all 4 `mem_req` cycles. `b_rdata` unchanged. `b_stall` high 5 cycles.
- A holds `a_req` high across its done cycle with the same access → exactly one memory transaction is issued, not two.
- Assert `rst` low during GNT_A with `mem_ready` low → `mem_req` = 0 immediately. After release, state is IDLE and a new request is served normally.
- B request withdrawn while granted → transaction completes, `b_done` pulses once, and an A request waiting behind it is served next.

Source files
------------

// File: rtl/dual_core_mem_arbiter_if.sv
// Core/memory bus bundle shared by the dual-core data-memory arbiter.
// Latency: none, this file holds wires only.
// Backpressure: the arbiter stalls cores with *_stall, and the memory stalls the arbiter by holding off mem_ready.
// Ports:
//   Per-core side (a_*, b_*): req/we/addr/wdata come in; rdata/stall go out.
//   Memory side: mem_req/we/addr/wdata go out; mem_ready/mem_rdata come in.
//   last_grant: owner of the last completed access (0 = A, 1 = B).
// Modports:
//   master: the arbiter, which drives the memory bus.
//   slave:  the cores and the memory around it.
interface dual_core_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic [DW-1:0] a_rdata;
  logic          a_stall;
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic [DW-1:0] b_rdata;
  logic          b_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          last_grant;

  modport master (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_ready, mem_rdata,
    output a_rdata, a_stall, b_rdata, b_stall, mem_req, mem_we, mem_addr, mem_wdata, last_grant
  );

  modport slave (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_ready, mem_rdata,
    input  a_rdata, a_stall, b_rdata, b_stall, mem_req, mem_we, mem_addr, mem_wdata, last_grant
  );
endinterface

// File: rtl/dual_core_mem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between MIPS cores A and B.
// Latency: mem_req goes high one cycle after the request; completion (rdata, stall release) comes one cycle after mem_ready.
// Backpressure: the requesting core stalls until its completion cycle, and the memory bus holds steady until mem_ready.
// Ports:
//   clk: rising-edge clock.
//   rst: asynchronous active-low reset.
//   bus: the core/memory bundle (master modport).
module dual_core_mem_arbiter (
  input logic                     clk,
  input logic                     rst,
  dual_core_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t state, nextState;
  logic   aDone, bDone, lastGrant;
  logic   aEff, bEff;
  logic   grantA, grantB, complete;

  // While the done flag is set the core still presents the access that just finished.
  // Masking that access keeps it from being issued a second time.
  assign aEff = bus.a_req & ~aDone;
  assign bEff = bus.b_req & ~bDone;

  assign bus.a_stall    = aEff;
  assign bus.b_stall    = bEff;
  assign bus.last_grant = lastGrant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    grantA    = 1'b0;
    grantB    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, the core that did not own the last access wins.
        if (aEff && (!bEff || lastGrant)) begin
          grantA    = 1'b1;
          nextState = GNT_A;
        end else if (bEff) begin
          grantB    = 1'b1;
          nextState = GNT_B;
        end
      end
      GNT_A, GNT_B: begin
        if (bus.mem_ready) begin
          complete  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.a_rdata   <= '0;
      bus.b_rdata   <= '0;
      aDone         <= 1'b0;
      bDone         <= 1'b0;
      lastGrant     <= 1'b1;
    end else begin
      aDone <= 1'b0;
      bDone <= 1'b0;
      if (grantA) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.a_we;
        bus.mem_addr  <= bus.a_addr;
        bus.mem_wdata <= bus.a_wdata;
      end else if (grantB) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.b_we;
        bus.mem_addr  <= bus.b_addr;
        bus.mem_wdata <= bus.b_wdata;
      end else if (complete) begin
        // The access completes even if the owner dropped its request meanwhile.
        bus.mem_req <= 1'b0;
        if (state == GNT_A) begin
          aDone     <= 1'b1;
          lastGrant <= 1'b0;
          if (!bus.mem_we) bus.a_rdata <= bus.mem_rdata;
        end else begin
          bDone     <= 1'b1;
          lastGrant <= 1'b1;
          if (!bus.mem_we) bus.b_rdata <= bus.mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
module tb_dual_core_mem_arbiter;

  typedef struct {
    logic        core;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   waitCycles  = 0;
  int   txCount     = 0;
  logic [31:0] expA = '0;
  logic [31:0] expB = '0;
  logic [31:0] memModel [logic [31:0]];
  txn_t sb [$];

  dual_core_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dual_core_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdFn(input logic [31:0] addr);
    if (memModel.exists(addr)) return memModel[addr];
    return addr ^ 32'h5A5A_0000;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drvA(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
  endtask

  task automatic drvB(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
  endtask

  task automatic push(input logic core, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.core = core; t.we = we; t.addr = addr; t.wdata = wdata;
    sb.push_back(t);
  endtask

  task automatic doReset();
    step();
    rst = 1'b0;
    drvA(1'b0, 1'b0, '0, '0);
    drvB(1'b0, 1'b0, '0, '0);
    expA = '0;
    expB = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Memory model and scoreboard. At each falling edge it answers the registered
  // request after waitCycles wait cycles and checks the access against the
  // oldest expected transaction. One cycle later it checks the owner's read
  // data and last_grant.
  initial begin : memModelProc
    int   cnt;
    logic pendValid;
    logic pendCore;
    txn_t t;
    cnt       = 0;
    pendValid = 1'b0;
    pendCore  = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pendValid) begin
        if (pendCore) chk("sb_b_rdata", bus.b_rdata, expB);
        else          chk("sb_a_rdata", bus.a_rdata, expA);
        chk("sb_last_grant", bus.last_grant, pendCore);
        pendValid = 1'b0;
      end
      if (!rst || !bus.mem_req) begin
        bus.mem_ready = 1'b0;
        cnt = 0;
      end else if (cnt < waitCycles) begin
        bus.mem_ready = 1'b0;
        cnt++;
      end else begin
        bus.mem_ready = 1'b1;
        cnt = 0;
        txCount++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_txn", 32'd1, 32'd0);
        end else begin
          t = sb.pop_front();
          chk("sb_mem_we", bus.mem_we, t.we);
          chk("sb_mem_addr", bus.mem_addr, t.addr);
          chk("sb_mem_wdata", bus.mem_wdata, t.wdata);
          if (t.we) begin
            memModel[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata = $urandom;
          end else begin
            bus.mem_rdata = rdFn(bus.mem_addr);
            if (t.core) expB = bus.mem_rdata;
            else        expA = bus.mem_rdata;
          end
          pendValid = 1'b1;
          pendCore  = t.core;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    int t0;
    int budget;
    memModel[32'h40] = 32'hDEADBEEF;
    rst = 1'b0;
    drvA(1'b0, 1'b0, '0, '0);
    drvB(1'b0, 1'b0, '0, '0);

    // Reset values
    step();
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_a_rdata", bus.a_rdata, '0);
    chk("rst_b_rdata", bus.b_rdata, '0);
    chk("rst_last_grant", bus.last_grant, 1'b1);
    chk("rst_a_stall_idle", bus.a_stall, 1'b0);
    bus.a_req = 1'b1; #1;
    chk("rst_a_stall_follows_req", bus.a_stall, 1'b1);
    bus.a_req = 1'b0;
    step();
    rst = 1'b1;

    // Single A load, zero wait
    step();
    drvA(1'b1, 1'b0, 32'h40, 32'h0); push(1'b0, 1'b0, 32'h40, 32'h0); #1;
    chk("t1_c0_a_stall", bus.a_stall, 1'b1);
    chk("t1_c0_mem_req", bus.mem_req, 1'b0);
    step();
    chk("t1_c1_mem_req", bus.mem_req, 1'b1);
    chk("t1_c1_mem_addr", bus.mem_addr, 32'h40);
    chk("t1_c1_a_stall", bus.a_stall, 1'b1);
    step();
    chk("t1_c2_a_stall", bus.a_stall, 1'b0);
    chk("t1_c2_a_rdata", bus.a_rdata, 32'hDEADBEEF);
    chk("t1_c2_last_grant", bus.last_grant, 1'b0);
    bus.a_req = 1'b0;

    // Simultaneous requests after reset, then round-robin
    doReset();
    step();
    drvA(1'b1, 1'b0, 32'h100, 32'h0); drvB(1'b1, 1'b0, 32'h200, 32'h0);
    push(1'b0, 1'b0, 32'h100, 32'h0); push(1'b1, 1'b0, 32'h200, 32'h0); #1;
    chk("t2_c0_b_stall", bus.b_stall, 1'b1);
    step();
    chk("t2_c1_mem_addr_a", bus.mem_addr, 32'h100);
    step();
    chk("t2_c2_a_stall", bus.a_stall, 1'b0);
    chk("t2_c2_b_stall", bus.b_stall, 1'b1);
    chk("t2_c2_mem_req", bus.mem_req, 1'b0);
    chk("t2_c2_a_rdata", bus.a_rdata, 32'h5A5A0100);
    bus.a_req = 1'b0;
    step();
    chk("t2_c3_mem_req", bus.mem_req, 1'b1);
    chk("t2_c3_mem_addr_b", bus.mem_addr, 32'h200);
    step();
    chk("t2_c4_b_stall", bus.b_stall, 1'b0);
    chk("t2_c4_b_rdata", bus.b_rdata, 32'h5A5A0200);
    bus.b_req = 1'b0;
    step();
    drvA(1'b1, 1'b0, 32'h104, 32'h0); drvB(1'b1, 1'b0, 32'h204, 32'h0);
    push(1'b0, 1'b0, 32'h104, 32'h0); push(1'b1, 1'b0, 32'h204, 32'h0);
    step();
    chk("t2_c6_tie_to_a", bus.mem_addr, 32'h104);
    step();
    chk("t2_c7_a_stall", bus.a_stall, 1'b0);
    drvA(1'b1, 1'b0, 32'h108, 32'h0); push(1'b0, 1'b0, 32'h108, 32'h0);
    step();
    chk("t2_c8_b_after_a", bus.mem_addr, 32'h204);
    chk("t2_c8_a_waits", bus.a_stall, 1'b1);
    step();
    chk("t2_c9_b_stall", bus.b_stall, 1'b0);
    bus.b_req = 1'b0;
    step();
    chk("t2_c10_mem_addr", bus.mem_addr, 32'h108);
    step();
    chk("t2_c11_a_rdata", bus.a_rdata, 32'h5A5A0108);
    bus.a_req = 1'b0;

    // B store with three wait cycles
    waitCycles = 3;
    step();
    drvB(1'b1, 1'b1, 32'h80, 32'h12345678); push(1'b1, 1'b1, 32'h80, 32'h12345678); #1;
    chk("t3_c0_b_stall", bus.b_stall, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t3_mem_req", bus.mem_req, 1'b1);
      chk("t3_mem_we", bus.mem_we, 1'b1);
      chk("t3_mem_addr", bus.mem_addr, 32'h80);
      chk("t3_mem_wdata", bus.mem_wdata, 32'h12345678);
      chk("t3_b_stall", bus.b_stall, 1'b1);
    end
    step();
    chk("t3_c5_b_stall", bus.b_stall, 1'b0);
    chk("t3_c5_b_rdata_kept", bus.b_rdata, 32'h5A5A0204);
    chk("t3_c5_mem_req", bus.mem_req, 1'b0);
    bus.b_req = 1'b0;
    waitCycles = 0;

    // A holds its request across the done cycle: one transaction only
    t0 = txCount;
    step();
    drvA(1'b1, 1'b0, 32'h80, 32'h0); push(1'b0, 1'b0, 32'h80, 32'h0);
    step();
    step();
    chk("t4_c2_a_stall", bus.a_stall, 1'b0);
    chk("t4_c2_a_rdata_stored", bus.a_rdata, 32'h12345678);
    step();
    bus.a_req = 1'b0;
    step();
    chk("t4_c4_mem_req", bus.mem_req, 1'b0);
    step();
    chk("t4_tx_count", txCount - t0, 1);

    // Reset during GNT_A with the memory still busy
    waitCycles = 5;
    step();
    drvA(1'b1, 1'b0, 32'h44, 32'h0);
    step();
    chk("t5_c1_mem_req", bus.mem_req, 1'b1);
    step();
    rst = 1'b0; #1;
    chk("t5_abort_mem_req", bus.mem_req, 1'b0);
    chk("t5_abort_last_grant", bus.last_grant, 1'b1);
    chk("t5_abort_a_stall", bus.a_stall, 1'b1);
    drvA(1'b0, 1'b0, '0, '0);
    expA = '0; expB = '0;
    step();
    step();
    rst = 1'b1;
    waitCycles = 0;
    step();
    drvA(1'b1, 1'b0, 32'h40, 32'h0); push(1'b0, 1'b0, 32'h40, 32'h0);
    step();
    chk("t5_post_mem_req", bus.mem_req, 1'b1);
    chk("t5_post_mem_addr", bus.mem_addr, 32'h40);
    step();
    chk("t5_post_a_stall", bus.a_stall, 1'b0);
    chk("t5_post_a_rdata", bus.a_rdata, 32'hDEADBEEF);
    bus.a_req = 1'b0;

    // B withdraws while granted, A waits behind it
    waitCycles = 2;
    step();
    drvB(1'b1, 1'b0, 32'h300, 32'h0); push(1'b1, 1'b0, 32'h300, 32'h0);
    step();
    chk("t6_c1_mem_addr", bus.mem_addr, 32'h300);
    drvA(1'b1, 1'b0, 32'h44, 32'h0); push(1'b0, 1'b0, 32'h44, 32'h0); #1;
    chk("t6_c1_a_stall", bus.a_stall, 1'b1);
    step();
    bus.b_req = 1'b0; #1;
    chk("t6_c2_b_stall", bus.b_stall, 1'b0);
    chk("t6_c2_mem_req_held", bus.mem_req, 1'b1);
    step();
    chk("t6_c3_mem_addr", bus.mem_addr, 32'h300);
    step();
    chk("t6_c4_b_rdata", bus.b_rdata, 32'h5A5A0300);
    chk("t6_c4_last_grant", bus.last_grant, 1'b1);
    chk("t6_c4_a_stall", bus.a_stall, 1'b1);
    step();
    chk("t6_c5_mem_addr_a", bus.mem_addr, 32'h44);
    budget = 20;
    while (bus.a_stall && budget > 0) begin
      step();
      budget--;
    end
    chk("t6_a_done_in_time", {31'd0, bus.a_stall}, 32'd0);
    chk("t6_a_rdata", bus.a_rdata, 32'h5A5A0044);
    bus.a_req = 1'b0;
    waitCycles = 0;

    step();
    step();
    step();
    chk("end_sb_empty", sb.size(), 0);
    chk("end_mem_req", bus.mem_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
